// File: rtl/sprite_line_scan.sv
// Per-scanline OAM search: walks every OAM entry, applies the Y-range test and
// keeps the first MAX_SPRITES hits (X and OAM index) in OAM order for the sorter.
module sprite_line_scan #(
    parameter int OAM_ENTRIES = 40,
    parameter int MAX_SPRITES = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 line,
    input  logic                       size16,
    output logic [5:0]                 oam_addr,
    input  logic [7:0]                 oam_y,
    input  logic [7:0]                 oam_x,
    output logic                       busy,
    output logic                       done,
    output logic [3:0]                 count,
    output logic [8*MAX_SPRITES-1:0]   x,
    output logic [6*MAX_SPRITES-1:0]   oam_idx
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_DONE} state_t;

    localparam logic [5:0] LAST_ADDR = 6'(OAM_ENTRIES - 1);
    localparam logic [3:0] MAX_CNT   = 4'(MAX_SPRITES);

    state_t      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  line_q, line_d;
    logic        size16_q, size16_d;
    logic        rd_valid_q, rd_valid_d;
    logic [5:0]  rd_idx_q, rd_idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  x_q   [MAX_SPRITES];
    logic [7:0]  x_d   [MAX_SPRITES];
    logic [5:0]  idx_q [MAX_SPRITES];
    logic [5:0]  idx_d [MAX_SPRITES];

    logic signed [9:0] diff;
    logic signed [9:0] height;
    logic              hit;
    logic              slot_wr;

    // rd_valid_q/rd_idx_q track the entry whose Y/X bytes are on the bus this
    // cycle, since the OAM read lags the issued address by one clock.
    always_comb begin
        diff    = signed'(({2'b00, line_q} + 10'd16) - {2'b00, oam_y});
        height  = size16_q ? 10'sd16 : 10'sd8;
        hit     = rd_valid_q && (diff >= 10'sd0) && (diff < height);
        slot_wr = !start && hit && (count_q < MAX_CNT);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        line_d     = line_q;
        size16_d   = size16_q;
        rd_valid_d = 1'b0;
        rd_idx_d   = rd_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;

        if (start) begin
            state_d  = S_ADDR;
            addr_d   = 6'd0;
            line_d   = line;
            size16_d = size16;
            busy_d   = 1'b1;
            count_d  = 4'd0;
        end else begin
            rd_valid_d = (state_q == S_ADDR);
            rd_idx_d   = addr_q;
            case (state_q)
                S_ADDR: begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 6'd1;
                    end
                end
                S_DRAIN: state_d = S_DONE;
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (slot_wr) begin
                count_d = count_q + 4'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_SPRITES; gi++) begin : g_slot
            always_comb begin
                x_d[gi]   = x_q[gi];
                idx_d[gi] = idx_q[gi];
                if (start) begin
                    x_d[gi]   = 8'hFF;
                    idx_d[gi] = 6'd0;
                end else if (slot_wr && (count_q == 4'(gi))) begin
                    x_d[gi]   = oam_x;
                    idx_d[gi] = rd_idx_q;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    x_q[gi]   <= 8'hFF;
                    idx_q[gi] <= 6'd0;
                end else begin
                    x_q[gi]   <= x_d[gi];
                    idx_q[gi] <= idx_d[gi];
                end
            end

            assign x[8*gi +: 8]       = x_q[gi];
            assign oam_idx[6*gi +: 6] = idx_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 6'd0;
            line_q     <= 8'd0;
            size16_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= 6'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            size16_q   <= size16_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

    assign oam_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;

endmodule

// File: tb/tb_sprite_line_scan.sv
// Directed bench for sprite_line_scan with a 1-cycle synchronous OAM model.
module tb_sprite_line_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  line;
    logic        size16;
    logic [5:0]  oam_addr;
    logic [7:0]  oam_y;
    logic [7:0]  oam_x;
    logic        busy;
    logic        done;
    logic [3:0]  count;
    logic [79:0] x;
    logic [59:0] oam_idx;

    logic [7:0]  mem_y [64];
    logic [7:0]  mem_x [64];

    logic [79:0] exp_x;
    logic [59:0] exp_i;
    int          exp_n;
    int          n_checks = 0;
    int          n_fail   = 0;

    sprite_line_scan dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .line     (line),
        .size16   (size16),
        .oam_addr (oam_addr),
        .oam_y    (oam_y),
        .oam_x    (oam_x),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .x        (x),
        .oam_idx  (oam_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        oam_y <= mem_y[oam_addr];
        oam_x <= mem_x[oam_addr];
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic oam_clear();
        for (int i = 0; i < 64; i++) begin
            mem_y[i] = 8'd0;
            mem_x[i] = 8'h20;
        end
    endtask

    task automatic exp_clear();
        exp_x = '1;
        exp_i = '0;
        exp_n = 0;
    endtask

    task automatic exp_add(input logic [7:0] xv, input logic [5:0] iv);
        exp_x[exp_n*8 +: 8] = xv;
        exp_i[exp_n*6 +: 6] = iv;
        exp_n++;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count"}, 80'(count), 80'(exp_n));
        check({tag, "_x"}, x, exp_x);
        check({tag, "_idx"}, 80'(oam_idx), 80'(exp_i));
    endtask

    // Pulses start, optionally restarts at a given cycle, and waits (bounded) for done.
    task automatic run_scan(input string tag, input logic [7:0] ln, input logic s16,
                            input int restart_at, input logic [7:0] ln2);
        int cyc;
        bit restarted;
        restarted = 1'b0;
        line = ln; size16 = s16; start = 1'b1;
        @(negedge clk);
        start = 1'b0; line = ~ln; size16 = ~s16;
        cyc = 1;
        check({tag, "_busy_start"}, 80'(busy), 80'(1));
        while (!done && cyc < 200) begin
            if (restart_at > 0 && !restarted && cyc == restart_at) begin
                line = ln2; size16 = s16; start = 1'b1;
                @(negedge clk);
                start = 1'b0; line = ~ln2; size16 = ~s16;
                cyc = 1;
                restarted = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_latency"}, 80'(cyc), 80'(43));
        check({tag, "_busy_done"}, 80'(busy), 80'(0));
        check_results(tag);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 80'(done), 80'(0));
    endtask

    initial begin
        int seen_done;
        reset = 1'b1; start = 1'b0; line = 8'd0; size16 = 1'b0;
        oam_clear();
        repeat (3) @(negedge clk);
        exp_clear();
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_done", 80'(done), 80'(0));
        check("rst_addr", 80'(oam_addr), 80'(0));
        check_results("rst");
        reset = 1'b0;
        @(negedge clk);

        // line 0, 8 px: two hits, two misses
        oam_clear();
        mem_y[3] = 8'd16; mem_x[3] = 8'd40;
        mem_y[7] = 8'd9;  mem_x[7] = 8'd50;
        mem_y[8] = 8'd17; mem_x[8] = 8'd60;
        mem_y[9] = 8'd8;  mem_x[9] = 8'd70;
        exp_clear(); exp_add(8'd40, 6'd3); exp_add(8'd50, 6'd7);
        run_scan("basic", 8'd0, 1'b0, 0, 8'd0);

        // 16 px vs 8 px with d = 15
        oam_clear();
        mem_y[0] = 8'd11; mem_x[0] = 8'd45;
        exp_clear(); exp_add(8'd45, 6'd0);
        run_scan("tall16", 8'd10, 1'b1, 0, 8'd0);
        exp_clear();
        run_scan("tall8", 8'd10, 1'b0, 0, 8'd0);

        // all entries hit: first ten kept in order
        oam_clear();
        for (int i = 0; i < 40; i++) begin
            mem_y[i] = 8'd60; mem_x[i] = 8'(i + 1);
        end
        exp_clear();
        for (int i = 0; i < 10; i++) exp_add(8'(i + 1), 6'(i));
        run_scan("full", 8'd50, 1'b0, 0, 8'd0);

        // boundaries
        oam_clear();
        mem_y[0] = 8'd160; mem_x[0] = 8'd77;
        mem_y[1] = 8'd170; mem_x[1] = 8'd88;
        exp_clear(); exp_add(8'd77, 6'd0);
        run_scan("ly153", 8'd153, 1'b1, 0, 8'd0);

        oam_clear();
        mem_x[5] = 8'd33;
        exp_clear();
        run_scan("y0", 8'd0, 1'b0, 0, 8'd0);

        oam_clear();
        mem_y[4] = 8'd255; mem_x[4] = 8'd44;
        mem_y[6] = 8'd159; mem_x[6] = 8'd12;
        exp_clear(); exp_add(8'd12, 6'd6);
        run_scan("nowrap", 8'd143, 1'b1, 0, 8'd0);

        // restart at cycle 20 with a different line
        oam_clear();
        mem_y[2]  = 8'd16; mem_x[2]  = 8'd5;
        mem_y[12] = 8'd60; mem_x[12] = 8'd99;
        mem_y[13] = 8'd60; mem_x[13] = 8'd98;
        exp_clear(); exp_add(8'd99, 6'd12); exp_add(8'd98, 6'd13);
        run_scan("restart", 8'd0, 1'b0, 20, 8'd50);

        // reset mid-scan
        oam_clear();
        for (int i = 0; i < 40; i++) begin
            mem_y[i] = 8'd60; mem_x[i] = 8'(i + 1);
        end
        line = 8'd50; size16 = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("midrst_pre_count", 80'(count), 80'(10));
        reset = 1'b1;
        @(negedge clk);
        exp_clear();
        check("midrst_busy", 80'(busy), 80'(0));
        check("midrst_done", 80'(done), 80'(0));
        check("midrst_addr", 80'(oam_addr), 80'(0));
        check_results("midrst");
        reset = 1'b0;
        seen_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("midrst_no_done", 80'(seen_done), 80'(0));
        for (int i = 0; i < 10; i++) exp_add(8'(i + 1), 6'(i));
        run_scan("postrst", 8'd50, 1'b0, 0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_line_scan.md
# sprite_line_scan

Per-scanline OAM search stage that feeds the sprite sorter. On each line start it walks all 40 OAM entries in index order, applies the Y-range test for 8x8 or 8x16 sprites, and latches the first 10 hits. It then presents their X coordinates and OAM numbers as flat vectors and pulses `done`, which drives the sorter's `load` input. The sorter's slot indices map back to OAM entries through `oam_idx`.

## Interface
- `OAM_ENTRIES`, 40: number of OAM entries scanned; indices 0..39.
- `MAX_SPRITES`, 10: selection slots; must match the sorter's `WIDTH`.

- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse at the start of mode 2 for the current line.
- `line`  in  8: current LY; sampled on the `start` edge and held internally.
- `size16`  in  1: LCDC.2 (0 = 8 px, 1 = 16 px tall); sampled on the `start` edge.
- `oam_addr`  out  6: OAM entry number being read.
- `oam_y`  in  8: Y byte of the entry addressed in the previous cycle (1-cycle synchronous RAM).
- `oam_x`  in  8: X byte, same timing as `oam_y`.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle pulse when results are final; connects to sorter `load`.
- `count`  out  4: number of selected sprites, 0..10.
- `x`  out  8*MAX_SPRITES: slot s at bits [8s+7:8s]; unused slots are 8'hFF.
- `oam_idx`  out  6*MAX_SPRITES: OAM entry number per slot; unused slots are 6'd0.

## Operation
- FSM states:
  - IDLE: waiting for `start`.
  - ADDR: issues addresses; the compare pipeline runs one cycle behind.
  - DRAIN: compares the final entry.
  - DONE: pulses `done`, then returns to IDLE.
- On `start`, from any state:
  - capture `line` and `size16`;
  - set `count` to 0, all `x` slots to FF, all `oam_idx` slots to 0;
  - set `oam_addr` to 0 and enter ADDR.
  - A `start` during ADDR, DRAIN or DONE aborts the current scan and restarts it. The aborted scan never produces `done`.
- ADDR increments `oam_addr` by 1 each cycle. After `oam_addr` = 39 is issued, the FSM enters DRAIN. `oam_addr` holds at 39 until the next `start`.
- Compare for entry k, done in the cycle after its address is issued:
  - h = 16 if `size16`, else 8.
  - d = line + 16 − oam_y, computed in 10-bit signed arithmetic with zero-extended inputs.
  - hit iff 0 ≤ d < h; equivalently oam_y ≤ line+16 < oam_y+h, with no 8-bit wrap.
- On a hit with `count` < 10:
  - slot[`count`] gets x = `oam_x` and oam_idx = k;
  - `count` increments.
- Hits after `count` reaches 10 are ignored. Entries with X = 0 or X ≥ 168 still occupy a slot, matching hardware behaviour.
- Entries are stored in OAM order. Equal-X tie-breaking is left to the sorter.
- Outputs stay stable from the `done` cycle until the next `start` or `reset`.

## Timing
- Let E0 be the clock edge that samples `start` = 1.
  - Entry k's address is valid in the cycle after edge E0+k.
  - Entry k is compared, and its slot written, at edge E0+k+2.
  - The last compare is at E0+41.
  - `done` is high for exactly the cycle after edge E0+42.
- Total latency from `start` to `done` is 43 cycles. With the sorter's 10 cycles, indices are final 53 cycles after `start`, within the 80-cycle mode 2 window.
- `busy` is high from edge E0 until `done` is high; it is 0 during the `done` cycle.
- Reset values:
  - IDLE state, `busy` = 0, `done` = 0, `count` = 0, `oam_addr` = 0;
  - all `x` slots = FF, all `oam_idx` slots = 0.
- `reset` mid-scan aborts with no `done`. `reset` and `start` in the same cycle: `reset` wins.
- `line` and `size16` changes during a scan have no effect.

## Test plan
- line = 0, 8 px mode:
  - stimulus: entry 3 with Y = 16, X = 40; entry 7 with Y = 9, X = 50; entry 8 with Y = 17, X = 60; entry 9 with Y = 8, X = 70.
  - required: `count` = 2, slot 0 = (40, 3), slot 1 = (50, 7), all other slots (FF, 0).
  - entry 8 misses (Y > line+16); entry 9 misses (d = 8, not < h).
- 16 px mode, line = 10: entry 0 with Y = 11 → hit (d = 15). The same entry in 8 px mode → miss.
- All 40 entries match:
  - `count` = 10 and `oam_idx` = 0..9 in order;
  - `done` high exactly 43 cycles after `start`, for exactly 1 cycle.
- Boundaries:
  - line = 153, Y = 160 → hit; Y = 170 → miss (d = −1).
  - line = 0, Y = 0 → miss (d = 16 is not < 8).
  - Y = 255 with line = 143, 16 px → miss (no wrap).
- `start` re-asserted at cycle 20 of a scan:
  - no `done` from the first scan;
  - `done` 43 cycles after the second `start`, with results reflecting only the second scan.
- `reset` asserted mid-scan: outputs return to reset values next cycle, `done` never pulses, and the next `start` scans normally.
